// File: rtl/seg7_display.sv
// seg7_display -- memory-mapped 8-digit seven-segment display controller.
//
// Accepts 16-bit I/O writes, builds a 32-bit value and a 16-bit control word,
// and shows the value either as hex nibbles or as decimal digits. Decimal
// digits come from a sequential double-dabble engine. Digits are
// time-multiplexed onto active-low anodes and segments.
//
// Ports:
//   clock      cpu clock
//   rst        async reset, active low
//   segcs      chip select
//   segwrite   write strobe
//   segaddr    00 value[15:0], 10 value[31:16], 01 control, 11 ignored
//   seg_wdata  write data
//   seg_busy   BCD conversion in progress
//   seg_en     digit anodes, active low, bit 0 = rightmost digit
//   seg_out    segments {dp,g,f,e,d,c,b,a}, active low
module seg7_display #(
   parameter int SCAN_DIV = 50000
) (
   input  logic        clock,
   input  logic        rst,
   input  logic        segcs,
   input  logic        segwrite,
   input  logic [1:0]  segaddr,
   input  logic [15:0] seg_wdata,
   output logic        seg_busy,
   output logic [7:0]  seg_en,
   output logic [7:0]  seg_out
);
   localparam int NUM_DIG = 8;
   localparam int BCD_DIG = 10;
   localparam int DIV_W   = $clog2(SCAN_DIV);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   logic [31:0]               value, value_nxt;
   logic [15:0]               ctrl, ctrl_nxt;
   logic                      wr_ev, start_q, hex_q, dec_load;
   state_t                    state, state_nxt;
   logic [4:0]                cnt;
   logic [31:0]               bin;
   logic [4*BCD_DIG-1:0]      bcd, bcd_adj;
   logic                      over;
   logic [NUM_DIG-1:0][3:0]   dig;
   logic [NUM_DIG-1:0]        dash;
   logic [DIV_W-1:0]          div;
   logic [2:0]                idx, idx_nxt;
   logic                      div_tc;
   logic [NUM_DIG-1:0]        zero_above;
   logic                      run, blank;
   logic [7:0]                code;
   logic [7:0]                dp_mask;

   // ---------------- register writes ----------------
   assign wr_ev = segcs & segwrite & (segaddr != 2'b11);

   always_comb begin
      value_nxt = value;
      ctrl_nxt  = ctrl;
      if (wr_ev) begin
         case (segaddr)
            2'b00:   value_nxt[15:0]  = seg_wdata;
            2'b10:   value_nxt[31:16] = seg_wdata;
            2'b01:   ctrl_nxt         = seg_wdata;
            default: ;
         endcase
      end
   end

   // start_q / hex_q act one cycle after the write, once value/ctrl hold the
   // freshly written contents.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         value   <= '0;
         ctrl    <= '0;
         start_q <= 1'b0;
         hex_q   <= 1'b0;
      end else begin
         value   <= value_nxt;
         ctrl    <= ctrl_nxt;
         start_q <= wr_ev &  ctrl_nxt[0];
         hex_q   <= wr_ev & ~ctrl_nxt[0];
      end
   end

   // ---------------- double-dabble FSM ----------------
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // A hex write aborts outright; a pending decimal start restarts from any
   // state. A write landing while in DONE holds DONE (no load) so busy stays
   // high until the restart takes over on the next edge.
   always_comb begin
      state_nxt = state;
      dec_load  = 1'b0;
      if (wr_ev && !ctrl_nxt[0]) begin
         state_nxt = S_IDLE;
      end else if (start_q) begin
         state_nxt = S_SHIFT;
      end else begin
         case (state)
            S_SHIFT: if (cnt == 5'd31) state_nxt = S_DONE;
            S_DONE: begin
               if (!wr_ev) begin
                  state_nxt = S_IDLE;
                  dec_load  = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign seg_busy = (state != S_IDLE);

   for (genvar g = 0; g < BCD_DIG; g++) begin : g_adj
      assign bcd_adj[4*g +: 4] = (bcd[4*g +: 4] >= 4'd5) ? bcd[4*g +: 4] + 4'd3
                                                          : bcd[4*g +: 4];
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         bin  <= '0;
         bcd  <= '0;
         cnt  <= '0;
         over <= 1'b0;
      end else if (start_q) begin
         bin  <= value;
         bcd  <= '0;
         cnt  <= '0;
         over <= (value > 32'd99_999_999);
      end else if (state == S_SHIFT) begin
         {bcd, bin} <= {bcd_adj[4*BCD_DIG-2:0], bin, 1'b0};
         cnt        <= cnt + 5'd1;
      end
   end

   // ---------------- display register ----------------
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         dig  <= '0;
         dash <= '0;
      end else if (hex_q) begin
         dig  <= value;
         dash <= '0;
      end else if (dec_load) begin
         dig  <= bcd[31:0];
         dash <= {NUM_DIG{over}};
      end
   end

   // ---------------- scan ----------------
   assign div_tc  = (div == DIV_W'(SCAN_DIV - 1));
   assign idx_nxt = div_tc ? idx + 3'd1 : idx;

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         div <= '0;
         idx <= '0;
      end else begin
         div <= div_tc ? '0 : div + DIV_W'(1);
         idx <= idx_nxt;
      end
   end

   assign seg_en = ~(8'b1 << idx);

   function automatic logic [7:0] seg_code(input logic [3:0] d);
      case (d)
         4'h0: seg_code = 8'hC0;  4'h1: seg_code = 8'hF9;
         4'h2: seg_code = 8'hA4;  4'h3: seg_code = 8'hB0;
         4'h4: seg_code = 8'h99;  4'h5: seg_code = 8'h92;
         4'h6: seg_code = 8'h82;  4'h7: seg_code = 8'hF8;
         4'h8: seg_code = 8'h80;  4'h9: seg_code = 8'h90;
         4'hA: seg_code = 8'h88;  4'hB: seg_code = 8'h83;
         4'hC: seg_code = 8'hC6;  4'hD: seg_code = 8'hA1;
         4'hE: seg_code = 8'h86;  default: seg_code = 8'h8E;
      endcase
   endfunction

   // zero_above[i]: digits i..7 are all zero (and none is a dash).
   always_comb begin
      zero_above = '0;
      run        = 1'b1;
      for (int i = NUM_DIG - 1; i >= 0; i--) begin
         run           = run & (dig[i] == 4'd0) & ~dash[i];
         zero_above[i] = run;
      end
   end

   // Decode the digit that will be lit next cycle so seg_out lines up with
   // seg_en.
   assign dp_mask = ctrl[15:8];
   assign blank   = ctrl[1] && (idx_nxt != 3'd0) && zero_above[idx_nxt];

   always_comb begin
      code = seg_code(dig[idx_nxt]);
      if (dash[idx_nxt])  code = 8'hBF;
      else if (blank)     code = 8'hFF;
      if (dp_mask[idx_nxt]) code[7] = 1'b0;
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) seg_out <= 8'hC0;
      else      seg_out <= code;
   end

endmodule
